// File: rtl/eth_tx_sched.sv
// Frame/packet transmit scheduler: START -> SEND -> GAP per packet, DONE after the last packet.
// Latency: pkt_start one cycle after an accepted frame_start or an expired gap; all pulses are registered.
// Backpressure: waits in SEND for pkt_done; abort returns to IDLE. ETH_TX_WDOG_EN adds a SEND watchdog.
module eth_tx_sched #(
    parameter int PKT_BYTES      = 320,
    parameter int PKTS_PER_FRAME = 240,
    parameter int IFG_CYCLES     = 48,
    parameter int WDOG_CYCLES    = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        abort,
    input  logic        pkt_done,
    output logic        pkt_start,
    output logic        cancelled,
    output logic [23:0] base_addr,
    output logic [15:0] pkt_idx,
    output logic        busy,
    output logic        frame_done,
    output logic        wdog_err
);

    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [23:0]        base_nxt;
    logic [15:0]        idx_nxt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_nxt;
    logic               pkt_start_nxt;
    logic               cancelled_nxt;
    logic               frame_done_nxt;
    logic               last_pkt;

    assign last_pkt = (pkt_idx == 16'(PKTS_PER_FRAME - 1));
    assign busy     = (state != IDLE);

`ifdef ETH_TX_WDOG_EN
    localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    logic [WD_W-1:0]    wdog_cnt;
    logic               wdog_trip;
    logic               wdog_err_nxt;

    // The counter value equals the number of completed SEND cycles; trip on the last allowed one.
    assign wdog_trip = (wdog_cnt == WD_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            wdog_err <= wdog_err_nxt;
            if (state != SEND)
                wdog_cnt <= '0;
            else
                wdog_cnt <= wdog_cnt + WD_W'(1);
        end
    end
`else
    assign wdog_err = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        base_nxt      = base_addr;
        idx_nxt       = pkt_idx;
        gap_nxt       = gap_cnt;
        cancelled_nxt = 1'b0;
`ifdef ETH_TX_WDOG_EN
        wdog_err_nxt  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (frame_start && !abort) begin
                    idx_nxt   = '0;
                    base_nxt  = '0;
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = abort ? IDLE : SEND;
            end
            SEND: begin
                if (abort) begin
                    state_nxt     = IDLE;
                    cancelled_nxt = 1'b1;
                end else if (pkt_done) begin
                    if (last_pkt) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt  = pkt_idx + 16'd1;
                        base_nxt = base_addr + 24'(PKT_BYTES);
                        if (IFG_CYCLES == 0) begin
                            state_nxt = START;
                        end else begin
                            gap_nxt   = GAP_W'(IFG_CYCLES);
                            state_nxt = GAP;
                        end
                    end
                end
`ifdef ETH_TX_WDOG_EN
                else if (wdog_trip) begin
                    state_nxt     = IDLE;
                    cancelled_nxt = 1'b1;
                    wdog_err_nxt  = 1'b1;
                end
`endif
            end
            GAP: begin
                gap_nxt = gap_cnt - GAP_W'(1);
                if (abort)
                    state_nxt = IDLE;
                else if (gap_cnt <= GAP_W'(1))
                    state_nxt = START;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Pulses are flopped alongside the state so they are high exactly while in START / DONE.
        pkt_start_nxt  = (state_nxt == START);
        frame_done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            base_addr  <= '0;
            pkt_idx    <= '0;
            gap_cnt    <= '0;
            pkt_start  <= 1'b0;
            cancelled  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            base_addr  <= base_nxt;
            pkt_idx    <= idx_nxt;
            gap_cnt    <= gap_nxt;
            pkt_start  <= pkt_start_nxt;
            cancelled  <= cancelled_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: doc/eth_tx_sched.md
ETH_TX_SCHED -- requirements
Module: eth_tx_sched

Interface
REQ-001 The block SHALL have parameter PKT_BYTES, default 320, payload bytes per packet (address stride).
REQ-002 The block SHALL have parameter PKTS_PER_FRAME, default 240, packets per video frame.
REQ-003 The block SHALL have parameter IFG_CYCLES, default 48, idle cycles between packets (96 bit times at 2 bits/cycle).
REQ-004 The block SHALL have parameter WDOG_CYCLES, default 4096, max SEND cycles before watchdog trip.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  system clock; all state changes on rising edge.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 frame_start  input  1  single-cycle request to transmit one frame.
REQ-009 abort  input  1  level; terminates the current frame.
REQ-010 pkt_done  input  1  single-cycle pulse from packer after packet tail sent.
REQ-011 pkt_start  output  1  single-cycle pulse telling packer to begin a packet.
REQ-012 cancelled  output  1  single-cycle pulse to packer to drop the packet in flight.
REQ-013 base_addr  output  24  pixel address of first payload byte of current packet.
REQ-014 pkt_idx  output  16  index of current packet within frame.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 frame_done  output  1  single-cycle pulse when last packet of frame completes.
REQ-017 wdog_err  output  1  single-cycle pulse on watchdog trip.

Function
REQ-018 FSM states SHALL be IDLE, START, SEND, GAP, DONE.
REQ-019 IDLE: on frame_start, pkt_idx<=0, base_addr<=0, next state START; frame_start while not IDLE SHALL be ignored.
REQ-020 START: pkt_start=1 for exactly this one cycle, next state SEND.
REQ-021 SEND: wait for pkt_done; pkt_done outside SEND SHALL be ignored.
REQ-022 SEND with pkt_done and pkt_idx==PKTS_PER_FRAME-1: next state DONE; indices unchanged.
REQ-023 SEND with pkt_done otherwise: pkt_idx+=1, base_addr+=PKT_BYTES (24-bit wrap), gap counter<=IFG_CYCLES, next state GAP.
REQ-024 GAP: decrement counter each cycle; leave to START on the cycle counter reaches 1, giving exactly IFG_CYCLES GAP cycles between pkt_done and the next START; IFG_CYCLES=0 SHALL go SEND->START directly.
REQ-025 DONE: frame_done=1 for this one cycle, next state IDLE.
REQ-026 abort high in START, SEND or GAP: next state IDLE; cancelled=1 that cycle only if state is SEND; pkt_start, frame_done suppressed; abort beats simultaneous pkt_done.
REQ-027 abort in IDLE SHALL block frame_start that same cycle; abort in DONE SHALL not suppress frame_done.
REQ-028 pkt_start, cancelled, frame_done, wdog_err SHALL be registered (no combinational path from inputs).
REQ-029 base_addr and pkt_idx SHALL hold their values in IDLE until the next accepted frame_start.

Reset
REQ-030 On rst low: state IDLE; pkt_idx=0, base_addr=0, gap and watchdog counters 0; all single-cycle outputs and busy 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame without emitting cancelled or frame_done.

Configuration
REQ-032 Macro ETH_TX_WDOG_EN SHALL compile in the SEND watchdog.
REQ-033 With ETH_TX_WDOG_EN: counter clears on entry to SEND, increments each SEND cycle; on WDOG_CYCLES without pkt_done, assert cancelled and wdog_err one cycle, next state IDLE; pkt_done on the trip cycle wins (no trip).
REQ-034 Without ETH_TX_WDOG_EN: no watchdog counter; wdog_err tied 0; SEND waits indefinitely.

Verification (PKT_BYTES=4, PKTS_PER_FRAME=3, IFG_CYCLES=2, WDOG_CYCLES=16)
REQ-035 frame_start, pkt_done 5 cycles after each pkt_start -> 3 pkt_start pulses with base_addr 0,4,8, pkt_idx 0,1,2, 2 GAP cycles each, frame_done once, busy low after.
REQ-036 abort during second SEND -> cancelled pulse once, no third pkt_start, no frame_done, IDLE next cycle.
REQ-037 frame_start repeated while busy, plus stray pkt_done in GAP -> ignored; sequence identical to REQ-035.
REQ-038 rst low during GAP of packet 1 -> all outputs 0 asynchronously; after release new frame_start begins at base_addr 0.
REQ-039 With ETH_TX_WDOG_EN, no pkt_done -> cancelled and wdog_err after 16 SEND cycles, IDLE; without macro, busy stays high, wdog_err 0.
REQ-040 IFG_CYCLES=0 build -> pkt_start exactly 1 cycle after each non-final pkt_done.
